// File: rtl/i2c_init_sequencer.sv
// Replays a host-loaded table of I2C register writes into an I2C write master on a go pulse.
// Define I2C_SEQ_GAP_EN to insert GAP_CYCLES idle cycles between consecutive transactions.
module i2c_init_sequencer #(
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 4096
`ifdef I2C_SEQ_GAP_EN
  ,
  parameter int GAP_CYCLES = 64
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [6:0]       cfg_addr,
  input  logic [7:0]       cfg_sub,
  input  logic [7:0]       cfg_data,
  input  logic             go,
  input  logic [IDX_W:0]   len,
  input  logic             i2c_ready,
  output logic             i2c_start,
  output logic [6:0]       i2c_addr,
  output logic [7:0]       i2c_sub,
  output logic [7:0]       i2c_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] cur_idx
);

  localparam int LEN_W   = IDX_W + 1;
  localparam int ENTRY_W = 7 + 8 + 8;
  localparam int WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
`ifdef I2C_SEQ_GAP_EN
    S_GAP,
`endif
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               error_q, error_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         sub_q, sub_d;
  logic [7:0]         data_q, data_d;
  logic [LEN_W-1:0]   len_eff;
  logic [ENTRY_W-1:0] table_q [DEPTH];

`ifdef I2C_SEQ_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // Requests longer than the table replay the whole table once.
  assign len_eff = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;

  // NOTE: the table is plain storage with no reset; resetting it would turn it into flops
  // with a reset tree for contents the host always reloads before use anyway.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      table_q[cfg_idx] <= {cfg_addr, cfg_sub, cfg_data};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      cur_idx_q <= '0;
      wd_q      <= '0;
      error_q   <= 1'b0;
      addr_q    <= '0;
      sub_q     <= '0;
      data_q    <= '0;
`ifdef I2C_SEQ_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cur_idx_q <= cur_idx_d;
      wd_q      <= wd_d;
      error_q   <= error_d;
      addr_q    <= addr_d;
      sub_q     <= sub_d;
      data_q    <= data_d;
`ifdef I2C_SEQ_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cur_idx_d = cur_idx_q;
    wd_d      = wd_q;
    error_d   = error_q;
    addr_d    = addr_q;
    sub_d     = sub_q;
    data_d    = data_q;
`ifdef I2C_SEQ_GAP_EN
    gap_d     = gap_q;
`endif
    i2c_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          error_d = 1'b0;
          if (len_eff != '0) begin
            last_d  = IDX_W'(len_eff - LEN_W'(1));
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_LOAD: begin
        busy                     = 1'b1;
        {addr_d, sub_d, data_d}  = table_q[idx_q];
        cur_idx_d                = idx_q;
        state_d                  = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (i2c_ready) begin
          i2c_start = 1'b1;
          wd_d      = '0;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        busy = 1'b1;
        wd_d = wd_q + WD_W'(1);
        if (!i2c_ready) state_d = S_WAIT_DONE;
        if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        wd_d = wd_q + WD_W'(1);
        // A ready return on the final budget cycle still counts as in time.
        if (i2c_ready) begin
          if (idx_q == last_q) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
`ifdef I2C_SEQ_GAP_EN
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_GAP;
`else
            state_d = S_LOAD;
`endif
          end
        end else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef I2C_SEQ_GAP_EN
      S_GAP: begin
        busy = 1'b1;
        if (gap_q == '0) state_d = S_LOAD;
        else             gap_d   = gap_q - GAP_W'(1);
      end
`endif
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i2c_addr = addr_q;
  assign i2c_sub  = sub_q;
  assign i2c_data = data_q;
  assign error    = error_q;
  assign cur_idx  = cur_idx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: behavioural write master with adjustable hold time,
// replay, len=0, clamping, watchdog, ignored cfg/go while running and mid-run reset.
module tb_i2c_init_sequencer;

  localparam int DEPTH   = 16;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 16;
`ifdef I2C_SEQ_GAP_EN
  localparam int GAP     = 5;
  localparam int EXP_GAP = GAP + 2;
`else
  localparam int EXP_GAP = 2;
`endif

  localparam logic [22:0] E0   = {7'h68, 8'h20, 8'h0F};
  localparam logic [22:0] E1   = {7'h68, 8'h23, 8'h30};
  localparam logic [22:0] E2   = {7'h68, 8'h24, 8'h00};
  localparam logic [22:0] JUNK = {7'h11, 8'h22, 8'h33};

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [6:0]       cfg_addr;
  logic [7:0]       cfg_sub;
  logic [7:0]       cfg_data;
  logic             go;
  logic [IDX_W:0]   len;
  logic             i2c_ready = 1'b1;
  logic             i2c_start;
  logic [6:0]       i2c_addr;
  logic [7:0]       i2c_sub;
  logic [7:0]       i2c_data;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] cur_idx;

  i2c_init_sequencer #(
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
`ifdef I2C_SEQ_GAP_EN
    ,
    .GAP_CYCLES (GAP)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_sub   (cfg_sub),
    .cfg_data  (cfg_data),
    .go        (go),
    .len       (len),
    .i2c_ready (i2c_ready),
    .i2c_start (i2c_start),
    .i2c_addr  (i2c_addr),
    .i2c_sub   (i2c_sub),
    .i2c_data  (i2c_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cur_idx   (cur_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Master model: ready drops the cycle after start and stays low m_hold cycles.
  int   m_hold = 15;
  int   m_cnt  = 0;
  logic m_hang = 1'b0;
  always @(posedge clk) begin
    if (i2c_ready && i2c_start) begin
      i2c_ready <= 1'b0;
      m_cnt     <= m_hold;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (!m_hang) begin
      i2c_ready <= 1'b1;
      m_cnt     <= 0;
    end
  end

  // Transaction log, sampled mid-cycle.
  int          n_start, n_done, n_busy, n_b2b, done_cyc, err_cyc;
  logic        done_busy;
  logic        prev_start = 1'b0;
  logic        prev_err   = 1'b0;
  int          st_cyc [32];
  logic [22:0] st_op  [32];

  always @(negedge clk) begin
    if (i2c_start) begin
      if (n_start < 32) begin
        st_cyc[n_start] = cyc;
        st_op[n_start]  = {i2c_addr, i2c_sub, i2c_data};
      end
      if (prev_start) n_b2b++;
      n_start++;
    end
    prev_start = i2c_start;
    if (done) begin
      done_cyc  = cyc;
      done_busy = busy;
      n_done++;
    end
    if (busy) n_busy++;
    if (error && !prev_err) err_cyc = cyc;
    prev_err = error;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    n_start = 0; n_done = 0; n_busy = 0; n_b2b = 0;
    done_cyc = -1; err_cyc = -1; done_busy = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input logic [22:0] v);
    cfg_we  = 1'b1;
    cfg_idx = IDX_W'(idx);
    {cfg_addr, cfg_sub, cfg_data} = v;
    tick(1);
    cfg_we  = 1'b0;
  endtask

  task automatic start_go(input int l, output int g);
    go  = 1'b1;
    len = (IDX_W+1)'(l);
    g   = cyc;
    tick(1);
    go  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) tick(1);
    check(tag, n_done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_sub = '0; cfg_data = '0;
    go = 1'b0; len = '0;
    tick(3);
    @(negedge clk);
    check("rst_start",   i2c_start, 0);
    check("rst_ops",     {i2c_addr, i2c_sub, i2c_data}, 0);
    check("rst_flags",   {busy, done, error}, 0);
    check("rst_cur_idx", cur_idx, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    cfg_write(0, E0);
    cfg_write(1, E1);
    cfg_write(2, E2);
    tick(2);

    // Run 1: three entries; cfg write and go injected mid-run must be ignored.
    m_hold = 15;
    clear_log();
    start_go(3, g);
    for (int i = 0; i < 300 && n_done == 0; i++) begin
      cfg_we = (i == 4);
      go     = (i == 4);
      if (i == 4) begin
        cfg_idx = 1;
        {cfg_addr, cfg_sub, cfg_data} = JUNK;
        len = 1;
      end
      tick(1);
    end
    cfg_we = 1'b0; go = 1'b0;
    tick(2);
    check("r1_starts",    n_start, 3);
    check("r1_op0",       st_op[0], E0);
    check("r1_op1",       st_op[1], E1);
    check("r1_op2",       st_op[2], E2);
    check("r1_go_lat",    st_cyc[0] - g, 2);
    check("r1_ready2st",  st_cyc[1] - st_cyc[0], m_hold + 1 + EXP_GAP);
    check("r1_done_cnt",  n_done, 1);
    check("r1_done_lat",  done_cyc - st_cyc[2], m_hold + 2);
    check("r1_done_busy", done_busy, 0);
    check("r1_flags",     {busy, error}, 0);
    check("r1_cur_idx",   cur_idx, 2);
    check("r1_b2b",       n_b2b, 0);

    // Run 2: replay shows entry 1 survived the ignored write.
    clear_log();
    start_go(3, g);
    wait_done("r2_done", 300);
    tick(2);
    check("r2_starts", n_start, 3);
    check("r2_op1",    st_op[1], E1);

    // Run 3: len=0 finishes at once without touching the bus.
    clear_log();
    start_go(0, g);
    tick(3);
    check("r3_starts",   n_start, 0);
    check("r3_done_cnt", n_done, 1);
    check("r3_done_lat", done_cyc - g, 1);
    check("r3_busy",     n_busy, 0);

    // Run 4: len above DEPTH is clamped to the whole table.
    m_hold = 2;
    clear_log();
    start_go(31, g);
    wait_done("r4_done", 400);
    tick(2);
    check("r4_starts",  n_start, DEPTH);
    check("r4_cur_idx", cur_idx, DEPTH - 1);
    check("r4_op0",     st_op[0], E0);

    // Run 5: master hangs after first start; watchdog fires, next go clears error.
    m_hang = 1'b1;
    clear_log();
    start_go(2, g);
    for (int i = 0; i < 60 && !error; i++) tick(1);
    tick(2);
    check("r5_starts",  n_start, 1);
    check("r5_err_lat", err_cyc - st_cyc[0], TIMEOUT + 1);
    check("r5_flags",   {busy, error}, 2'b01);
    check("r5_no_done", n_done, 0);
    m_hang = 1'b0;
    tick(3);
    clear_log();
    start_go(1, g);
    check("r5_err_clr", error, 0);
    wait_done("r5_rerun_done", 100);
    check("r5_rerun_err", error, 0);

    // Run 6: asynchronous reset during WAIT_DONE of entry 1.
    m_hold = 15;
    clear_log();
    start_go(3, g);
    for (int i = 0; i < 100 && n_start < 2; i++) tick(1);
    tick(5);
    check("r6_pre_idx", cur_idx, 1);
    #2;
    reset = 1'b0;
    #1;
    check("r6_rst_start",   i2c_start, 0);
    check("r6_rst_ops",     {i2c_addr, i2c_sub, i2c_data}, 0);
    check("r6_rst_flags",   {busy, done, error}, 0);
    check("r6_rst_cur_idx", cur_idx, 0);
    tick(2);
    reset = 1'b1;
    tick(40);
    check("r6_no_start", n_start, 2);
    check("r6_idle",     busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
